univ_shift_reg: RTL and testbench
=================================

// Module: univ_shift_reg
// PURPOSE
//  Parametrised successor to the 8-bit PIPO register: a WIDTH-bit shift register with
//  parallel load, serial in/out and a counted multi-step shift/rotate operation.
//  Requests use a start/busy/done handshake. Used wherever a datapath needs a word
//  loaded, then shifted or rotated by a run-time amount, under a simple controller.
// PARAMETERS
//  WIDTH      8   register width (>=2)
//  CNT_W      4   width of shift_cnt; max steps per request = 2**CNT_W-1
//  RESET_VAL  0   value of parallel_out after reset (WIDTH bits)
// PORTS
//  clk           in   1      single clock, all state on rising edge
//  reset_n       in   1      asynchronous, active-low reset
//  load          in   1      parallel load request (honoured only in IDLE)
//  parallel_in   in   WIDTH  data for load
//  start         in   1      shift request (honoured only in IDLE with load=0)
//  op            in   2      00 SHL, 01 SHR, 10 ROL, 11 ROR; latched at start
//  shift_cnt     in   CNT_W  number of one-bit steps; latched at start
//  serial_in     in   1      fill bit for SHL/SHR, sampled on every step edge
//  parallel_out  out  WIDTH  register contents
//  serial_out    out  1      bit that left (or wrapped) on the most recent step
//  busy          out  1      high while steps are pending
//  done          out  1      one-cycle pulse when a request completes
// BEHAVIOUR
//  - Reset (reset_n=0, async, any state): parallel_out=RESET_VAL, serial_out=0,
//    busy=0, done=0, remaining=0, FSM=IDLE. No done pulse on an aborted request.
//  - FSM states: IDLE, SHIFT.
//  - IDLE, load=1: parallel_out<=parallel_in at the next edge (1-cycle latency).
//    done is not pulsed. load beats start in the same cycle; start is dropped.
//  - IDLE, start=1, load=0, shift_cnt=0: no data change, done=1 for the next cycle,
//    busy stays 0, FSM stays IDLE.
//  - IDLE, start=1, load=0, shift_cnt=N>0 (edge E0): latch op and N, busy=1,
//    FSM->SHIFT. Steps occur at edges E1..EN, one per edge. After EN: busy=0,
//    done=1 for one cycle, FSM->IDLE. A new start is accepted while done=1.
//  - IDLE, neither load nor start: hold all state. done is cleared.
//  - Step (r = parallel_out, W = WIDTH):
//    SHL r<={r[W-2:0],serial_in}, serial_out<=r[W-1]
//    SHR r<={serial_in,r[W-1:1]}, serial_out<=r[0]
//    ROL r<={r[W-2:0],r[W-1]},    serial_out<=r[W-1]
//    ROR r<={r[0],r[W-1:1]},      serial_out<=r[0]
//  - In SHIFT, load, start, op and shift_cnt are ignored. Nothing is queued.
//  - N is performed literally. No clamping or modulo: SHL by N>=W leaves all
//    bits = the fill bits, and ROL/ROR by W returns the original word.
//  - serial_out changes only on step edges. It holds otherwise, including across
//    loads.
//  - remaining counter is CNT_W bits, decremented per step, and never wraps
//    below 0.
// STRUCTURE
//  - Package shift_pkg: typedef shift_op_t (SHL, SHR, ROL, ROR) and
//    typedef state_t (IDLE, SHIFT).
//  - Sub-module shift_step_unit: purely combinational. Inputs are r, op and
//    serial_in. Outputs are next r and the out bit. The top level holds the FSM,
//    the counter and the registers.
// TESTING
//  1 Reset, load 8'hCC, one edge -> parallel_out=8'hCC, busy=0, done=0.
//  2 From 8'hCC: start op=SHL, N=3, serial_in=1 -> busy high 3 cycles,
//    parallel_out=8'h67, serial_out=0, done pulses once, together with busy falling.
//  3 From 8'hA5: ROR, N=8 -> parallel_out=8'hA5, serial_out=1.
//    From 8'h81: SHR, N=2, serial_in=0 -> 8'h20, serial_out=0.
//  4 start with N=0 -> done pulses the next cycle, busy never high, data unchanged.
//    load+start in the same cycle -> load taken, no done.
//    load or start during busy -> ignored, and the request completes unchanged.
//  5 reset_n low mid-SHIFT (after step 2 of 5) -> outputs = reset values
//    immediately, no done. After release, a new request behaves normally.
//  6 WIDTH=16, CNT_W=5: ROL 16'h8001 by 17 -> 16'h0003. Back-to-back starts on the
//    done cycle are accepted.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared types for the universal shift register: shift operation codes and FSM states.
package shift_pkg;

  typedef enum logic [1:0] {
    SHL = 2'b00,
    SHR = 2'b01,
    ROL = 2'b10,
    ROR = 2'b11
  } shift_op_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/shift_step_unit.sv
// One-bit step of the shift register: next word and the bit that leaves (or wraps).
module shift_step_unit
  import shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_r,
  input  shift_op_t        i_op,
  input  logic             i_serial_in,
  output logic [WIDTH-1:0] o_r_next,
  output logic             o_out_bit
);

  // Select the shifted/rotated word and the departing bit for the latched operation
  always_comb begin
    o_r_next  = i_r;
    o_out_bit = 1'b0;
    case (i_op)
      SHL: begin
        o_r_next  = {i_r[WIDTH-2:0], i_serial_in};
        o_out_bit = i_r[WIDTH-1];
      end
      SHR: begin
        o_r_next  = {i_serial_in, i_r[WIDTH-1:1]};
        o_out_bit = i_r[0];
      end
      ROL: begin
        o_r_next  = {i_r[WIDTH-2:0], i_r[WIDTH-1]};
        o_out_bit = i_r[WIDTH-1];
      end
      ROR: begin
        o_r_next  = {i_r[0], i_r[WIDTH-1:1]};
        o_out_bit = i_r[0];
      end
      default: begin
        o_r_next  = i_r;
        o_out_bit = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/univ_shift_reg.sv
// WIDTH-bit shift register with parallel load and a counted shift/rotate request
// driven by a start/busy/done handshake.
module univ_shift_reg
  import shift_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               CNT_W     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] parallel_in,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [CNT_W-1:0] shift_cnt,
  input  logic             serial_in,
  output logic [WIDTH-1:0] parallel_out,
  output logic             serial_out,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] w_data_nxt;
  logic             r_sout;
  logic             w_sout_nxt;
  logic             r_busy;
  logic             w_busy_nxt;
  logic             r_done;
  logic             w_done_nxt;
  logic [CNT_W-1:0] r_remaining;
  logic [CNT_W-1:0] w_remaining_nxt;
  shift_op_t        r_op;
  shift_op_t        w_op_nxt;
  logic [WIDTH-1:0] w_step_r;
  logic             w_step_bit;

  shift_step_unit #(
    .WIDTH(WIDTH)
  ) u_step (
    .i_r        (r_data),
    .i_op       (r_op),
    .i_serial_in(serial_in),
    .o_r_next   (w_step_r),
    .o_out_bit  (w_step_bit)
  );

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and next-datapath decode; done defaults low so it is a one-cycle pulse
  always_comb begin
    w_state_nxt     = r_state;
    w_data_nxt      = r_data;
    w_sout_nxt      = r_sout;
    w_busy_nxt      = r_busy;
    w_done_nxt      = 1'b0;
    w_remaining_nxt = r_remaining;
    w_op_nxt        = r_op;
    case (r_state)
      IDLE: begin
        if (load) begin
          w_data_nxt = parallel_in;
        end else if (start) begin
          if (shift_cnt == CNT_ZERO) begin
            w_done_nxt = 1'b1;
          end else begin
            w_op_nxt        = shift_op_t'(op);
            w_remaining_nxt = shift_cnt;
            w_busy_nxt      = 1'b1;
            w_state_nxt     = SHIFT;
          end
        end else begin
          w_data_nxt = r_data;
        end
      end
      SHIFT: begin
        w_data_nxt = w_step_r;
        w_sout_nxt = w_step_bit;
        // The final step returns to IDLE; the counter saturates at zero
        if (r_remaining > CNT_ONE) begin
          w_remaining_nxt = r_remaining - CNT_ONE;
        end else begin
          w_remaining_nxt = CNT_ZERO;
          w_busy_nxt      = 1'b0;
          w_done_nxt      = 1'b1;
          w_state_nxt     = IDLE;
        end
      end
      default: begin
        w_state_nxt     = IDLE;
        w_busy_nxt      = 1'b0;
        w_remaining_nxt = CNT_ZERO;
      end
    endcase
  end

  // Datapath, handshake and counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data      <= RESET_VAL;
      r_sout      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_remaining <= CNT_ZERO;
      r_op        <= SHL;
    end else begin
      r_data      <= w_data_nxt;
      r_sout      <= w_sout_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_remaining <= w_remaining_nxt;
      r_op        <= w_op_nxt;
    end
  end

  assign parallel_out = r_data;
  assign serial_out   = r_sout;
  assign busy         = r_busy;
  assign done         = r_done;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg: an arithmetic reference model checked every
// cycle, plus directed vectors with hand-computed expectations (8-bit and 16-bit builds).
module tb_univ_shift_reg;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  // 8-bit instance
  logic       load8 = 1'b0, start8 = 1'b0, sin8 = 1'b0;
  logic [1:0] op8 = 2'd0;
  logic [3:0] cnt8 = 4'd0;
  logic [7:0] pin8 = 8'h00;
  logic [7:0] po8;
  logic       so8, busy8, done8;

  // 16-bit instance
  logic        load16 = 1'b0, start16 = 1'b0, sin16 = 1'b0;
  logic [1:0]  op16 = 2'd0;
  logic [4:0]  cnt16 = 5'd0;
  logic [15:0] pin16 = 16'h0000;
  logic [15:0] po16;
  logic        so16, busy16, done16;

  univ_shift_reg #(.WIDTH(8), .CNT_W(4), .RESET_VAL(8'h3C)) dut8 (
    .clk(clk), .reset_n(reset_n), .load(load8), .parallel_in(pin8), .start(start8),
    .op(op8), .shift_cnt(cnt8), .serial_in(sin8), .parallel_out(po8),
    .serial_out(so8), .busy(busy8), .done(done8)
  );

  univ_shift_reg #(.WIDTH(16), .CNT_W(5), .RESET_VAL(16'hA001)) dut16 (
    .clk(clk), .reset_n(reset_n), .load(load16), .parallel_in(pin16), .start(start16),
    .op(op16), .shift_cnt(cnt16), .serial_in(sin16), .parallel_out(po16),
    .serial_out(so16), .busy(busy16), .done(done16)
  );

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference step as plain arithmetic on an unsigned word value
  function automatic longint mnext(input int w, input longint r, input int o, input bit si);
    longint p, h;
    p = longint'(1) << w;
    h = p / 2;
    case (o)
      0:       return (r * 2 + longint'(si)) % p;
      1:       return r / 2 + longint'(si) * h;
      2:       return (r * 2) % p + r / h;
      default: return r / 2 + (r % 2) * h;
    endcase
  endfunction

  function automatic bit mbit(input int w, input longint r, input int o);
    longint h;
    h = (longint'(1) << w) / 2;
    if (o == 0 || o == 2) return bit'(r / h);
    else return bit'(r % 2);
  endfunction

  // Model: pending-step count plus word; busy is "steps still pending"
  logic [7:0]  m8_data;
  logic        m8_sout, m8_done;
  int          m8_pend, m8_op;
  logic [15:0] m16_data;
  logic        m16_sout, m16_done;
  int          m16_pend, m16_op;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m8_data <= 8'h3C; m8_sout <= 1'b0; m8_done <= 1'b0; m8_pend <= 0; m8_op <= 0;
    end else if (m8_pend == 0) begin
      m8_done <= 1'b0;
      if (load8) m8_data <= pin8;
      else if (start8 && cnt8 == 4'd0) m8_done <= 1'b1;
      else if (start8) begin m8_pend <= int'(cnt8); m8_op <= int'(op8); end
    end else begin
      m8_data <= 8'(mnext(8, longint'(m8_data), m8_op, sin8));
      m8_sout <= mbit(8, longint'(m8_data), m8_op);
      m8_pend <= m8_pend - 1;
      m8_done <= (m8_pend == 1);
    end
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m16_data <= 16'hA001; m16_sout <= 1'b0; m16_done <= 1'b0; m16_pend <= 0; m16_op <= 0;
    end else if (m16_pend == 0) begin
      m16_done <= 1'b0;
      if (load16) m16_data <= pin16;
      else if (start16 && cnt16 == 5'd0) m16_done <= 1'b1;
      else if (start16) begin m16_pend <= int'(cnt16); m16_op <= int'(op16); end
    end else begin
      m16_data <= 16'(mnext(16, longint'(m16_data), m16_op, sin16));
      m16_sout <= mbit(16, longint'(m16_data), m16_op);
      m16_pend <= m16_pend - 1;
      m16_done <= (m16_pend == 1);
    end
  end

  // Every-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("po8",    {8'h00, po8},      {8'h00, m8_data});
      cmp("so8",    {15'h0, so8},      {15'h0, m8_sout});
      cmp("busy8",  {15'h0, busy8},    {15'h0, (m8_pend != 0)});
      cmp("done8",  {15'h0, done8},    {15'h0, m8_done});
      cmp("po16",   po16,              m16_data);
      cmp("so16",   {15'h0, so16},     {15'h0, m16_sout});
      cmp("busy16", {15'h0, busy16},   {15'h0, (m16_pend != 0)});
      cmp("done16", {15'h0, done16},   {15'h0, m16_done});
    end
  end

  task automatic cyc8(input bit l, input bit s, input logic [1:0] o, input logic [3:0] n,
                      input bit si, input logic [7:0] p);
    @(negedge clk);
    load8 = l; start8 = s; op8 = o; cnt8 = n; sin8 = si; pin8 = p;
  endtask

  task automatic cyc16(input bit l, input bit s, input logic [1:0] o, input logic [4:0] n,
                       input bit si, input logic [15:0] p);
    @(negedge clk);
    load16 = l; start16 = s; op16 = o; cnt16 = n; sin16 = si; pin16 = p;
  endtask

  // Issue a request and idle until done is observed (bounded); nb counts busy cycles
  task automatic run8(input logic [1:0] o, input logic [3:0] n, input bit si, output int nb);
    bit seen;
    seen = 1'b0;
    nb = 0;
    cyc8(1'b0, 1'b1, o, n, si, 8'h00);
    for (int i = 0; i < 40 && !seen; i++) begin
      cyc8(1'b0, 1'b0, o, 4'd0, si, 8'h00);
      if (busy8) nb++;
      if (done8) seen = 1'b1;
    end
    if (!seen) begin
      n_vec++; n_err++;
      $display("FAIL run8_timeout: done got 0, expected 1 within 40 cycles");
    end
  endtask

  task automatic run16(input logic [1:0] o, input logic [4:0] n, input bit si, output int nb);
    bit seen;
    seen = 1'b0;
    nb = 0;
    cyc16(1'b0, 1'b1, o, n, si, 16'h0000);
    for (int i = 0; i < 60 && !seen; i++) begin
      cyc16(1'b0, 1'b0, o, 5'd0, si, 16'h0000);
      if (busy16) nb++;
      if (done16) seen = 1'b1;
    end
    if (!seen) begin
      n_vec++; n_err++;
      $display("FAIL run16_timeout: done got 0, expected 1 within 60 cycles");
    end
  endtask

  initial begin
    int nb;
    #1 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    cmp("rst_po8", {8'h00, po8}, 16'h003C);
    cmp("rst_po16", po16, 16'hA001);
    cmp("rst_hs8", {13'h0, so8, busy8, done8}, 16'h0000);
    reset_n = 1'b1;
    chk_en = 1'b1;

    // Load 8'hCC
    cyc8(1'b1, 1'b0, 2'd0, 4'd0, 1'b0, 8'hCC);
    cyc8(1'b0, 1'b0, 2'd0, 4'd0, 1'b0, 8'h00);
    cmp("load_cc", {8'h00, po8}, 16'h00CC);
    cmp("load_hs", {14'h0, busy8, done8}, 16'h0000);

    // SHL by 3 with fill 1
    run8(2'd0, 4'd3, 1'b1, nb);
    cmp("shl3_busy_cycles", 16'(nb), 16'd3);
    cmp("shl3_po", {8'h00, po8}, 16'h0067);
    cmp("shl3_so", {15'h0, so8}, 16'h0000);
    cmp("shl3_done_busy", {14'h0, busy8, done8}, 16'h0001);
    cyc8(1'b0, 1'b0, 2'd0, 4'd0, 1'b0, 8'h00);
    cmp("shl3_done_once", {15'h0, done8}, 16'h0000);

    // ROR by WIDTH returns the word
    cyc8(1'b1, 1'b0, 2'd0, 4'd0, 1'b0, 8'hA5);
    run8(2'd3, 4'd8, 1'b0, nb);
    cmp("ror8_po", {8'h00, po8}, 16'h00A5);
    cmp("ror8_so", {15'h0, so8}, 16'h0001);
    cmp("ror8_busy_cycles", 16'(nb), 16'd8);

    // SHR by 2 with fill 0
    cyc8(1'b1, 1'b0, 2'd0, 4'd0, 1'b0, 8'h81);
    run8(2'd1, 4'd2, 1'b0, nb);
    cmp("shr2_po", {8'h00, po8}, 16'h0020);
    cmp("shr2_so", {15'h0, so8}, 16'h0000);

    // Zero-count request
    cyc8(1'b0, 1'b0, 2'd0, 4'd0, 1'b0, 8'h00);
    cyc8(1'b0, 1'b1, 2'd0, 4'd0, 1'b0, 8'h00);
    cyc8(1'b0, 1'b0, 2'd0, 4'd0, 1'b0, 8'h00);
    cmp("n0_done", {14'h0, busy8, done8}, 16'h0001);
    cmp("n0_po", {8'h00, po8}, 16'h0020);
    cyc8(1'b0, 1'b0, 2'd0, 4'd0, 1'b0, 8'h00);
    cmp("n0_done_clear", {15'h0, done8}, 16'h0000);

    // Load wins over start
    cyc8(1'b1, 1'b1, 2'd0, 4'd3, 1'b0, 8'h5A);
    cyc8(1'b0, 1'b0, 2'd0, 4'd0, 1'b0, 8'h00);
    cmp("ld_st_po", {8'h00, po8}, 16'h005A);
    cmp("ld_st_hs", {14'h0, busy8, done8}, 16'h0000);

    // Load/start while busy are ignored: ROL 5A by 4 -> A5
    cyc8(1'b0, 1'b1, 2'd2, 4'd4, 1'b0, 8'h00);
    repeat (3) cyc8(1'b1, 1'b1, 2'd1, 4'd1, 1'b1, 8'hFF);
    cyc8(1'b0, 1'b0, 2'd0, 4'd0, 1'b0, 8'h00);
    cyc8(1'b0, 1'b0, 2'd0, 4'd0, 1'b0, 8'h00);
    cmp("ign_hs", {14'h0, busy8, done8}, 16'h0001);
    cmp("ign_po", {8'h00, po8}, 16'h00A5);
    cmp("ign_so", {15'h0, so8}, 16'h0001);

    // Reset after step 2 of 5
    cyc8(1'b1, 1'b0, 2'd0, 4'd0, 1'b0, 8'h0F);
    cyc8(1'b0, 1'b1, 2'd0, 4'd5, 1'b0, 8'h00);
    repeat (3) cyc8(1'b0, 1'b0, 2'd0, 4'd0, 1'b0, 8'h00);
    cmp("mid_busy", {15'h0, busy8}, 16'h0001);
    #2 reset_n = 1'b0;
    #1;
    cmp("abort_po8", {8'h00, po8}, 16'h003C);
    cmp("abort_hs8", {13'h0, so8, busy8, done8}, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) cyc8(1'b0, 1'b0, 2'd0, 4'd0, 1'b0, 8'h00);
    cmp("abort_no_done", {14'h0, busy8, done8}, 16'h0000);
    cyc8(1'b1, 1'b0, 2'd0, 4'd0, 1'b0, 8'h0F);
    run8(2'd0, 4'd5, 1'b0, nb);
    cmp("post_rst_po", {8'h00, po8}, 16'h00E0);
    cmp("post_rst_so", {15'h0, so8}, 16'h0001);
    cmp("post_rst_busy_cycles", 16'(nb), 16'd5);

    // 16-bit: ROL 8001 by 17
    cyc16(1'b1, 1'b0, 2'd0, 5'd0, 1'b0, 16'h8001);
    run16(2'd2, 5'd17, 1'b0, nb);
    cmp("rol17_po", po16, 16'h0003);
    cmp("rol17_so", {15'h0, so16}, 16'h0001);
    cmp("rol17_busy_cycles", 16'(nb), 16'd17);

    // Back-to-back: ROR 2 then SHL 1 started on the done cycle
    cyc16(1'b0, 1'b0, 2'd0, 5'd0, 1'b0, 16'h0000);
    cyc16(1'b0, 1'b1, 2'd3, 5'd2, 1'b0, 16'h0000);
    cyc16(1'b0, 1'b0, 2'd0, 5'd0, 1'b0, 16'h0000);
    cyc16(1'b0, 1'b0, 2'd0, 5'd0, 1'b0, 16'h0000);
    cyc16(1'b0, 1'b1, 2'd0, 5'd1, 1'b1, 16'h0000);
    cmp("b2b_done1", {15'h0, done16}, 16'h0001);
    cmp("b2b_po1", po16, 16'hC000);
    cyc16(1'b0, 1'b0, 2'd0, 5'd0, 1'b1, 16'h0000);
    cmp("b2b_busy2", {14'h0, busy16, done16}, 16'h0002);
    cyc16(1'b0, 1'b0, 2'd0, 5'd0, 1'b0, 16'h0000);
    cmp("b2b_done2", {14'h0, busy16, done16}, 16'h0001);
    cmp("b2b_po2", po16, 16'h8001);
    cmp("b2b_so2", {15'h0, so16}, 16'h0001);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
